// File: rtl/ex_13_pkg.sv
// Shared defaults and output-state encoding for the block accumulator.
package ex_13_pkg;

  localparam int DW_DEF     = 16;
  localparam int N_LOG2_DEF = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/ex_13_out_reg.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
//   state | meaning
//   EMPTY | no block held, out_valid=0
//   FULL  | completed block held, out_valid=1 until accepted
module ex_13_out_reg
  import ex_13_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DW+N_LOG2-1:0] load_sum,
  input  logic [DW-1:0]        load_max,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW+N_LOG2-1:0] out_sum,
  output logic [DW-1:0]        out_avg,
  output logic [DW-1:0]        out_max,
  output logic                 overrun
);

  out_state_e            state_q, state_d;
  logic [DW+N_LOG2-1:0]  sum_q, sum_d;
  logic [DW-1:0]         avg_q, avg_d;
  logic [DW-1:0]         max_q, max_d;
  logic                  ovr_q, ovr_d;
  logic                  capture;

  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    capture = 1'b0;
    case (state_q)
      EMPTY: begin
        if (load) begin
          capture = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          // accept and reload in the same cycle keeps the output bubble-free
          if (load) capture = 1'b1;
          else      state_d = EMPTY;
        end else if (load) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    sum_d = capture ? load_sum : sum_q;
    avg_d = capture ? load_sum[DW+N_LOG2-1:N_LOG2] : avg_q;
    max_d = capture ? load_max : max_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      avg_q   <= '0;
      max_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      max_q   <= max_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_sum   = sum_q;
  assign out_avg   = avg_q;
  assign out_max   = max_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/ex_13_accum.sv
// Block accumulator: sums and tracks the max of every 2**N_LOG2 valid samples,
// handing each completed block to the output holding register.
module ex_13_accum
  import ex_13_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW+N_LOG2-1:0] out_sum,
  output logic [DW-1:0]        out_avg,
  output logic [DW-1:0]        out_max,
  output logic                 overrun
);

  logic [DW+N_LOG2-1:0] acc_q, acc_d;
  logic [N_LOG2-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]        max_q, max_d;
  logic [DW+N_LOG2-1:0] sum_next;
  logic [DW-1:0]        max_next;
  logic                 complete;

  always_comb begin
    sum_next = acc_q + {{N_LOG2{1'b0}}, in_data};
    max_next = (in_data > max_q) ? in_data : max_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    complete = 1'b0;
    if (in_valid) begin
      if (&cnt_q) begin
        complete = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
        max_d    = '0;
      end else begin
        acc_d = sum_next;
        cnt_d = cnt_q + 1'b1;
        max_d = max_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      max_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
    end
  end

  ex_13_out_reg #(
    .DW     (DW),
    .N_LOG2 (N_LOG2)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (complete),
    .load_sum  (sum_next),
    .load_max  (max_next),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_max   (out_max),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_ex_13_accum.sv
// Scoreboard bench for ex_13_accum: stimulus queues expected blocks, a monitor
// compares every presented output and pops on handshake.
module tb_ex_13_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_sum;
  logic [15:0] out_avg;
  logic [15:0] out_max;
  logic        overrun;

  typedef struct {
    logic [18:0] sum;
    logic [15:0] avg;
    logic [15:0] mx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_13_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_max   (out_max),
    .overrun   (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle of input; returns 1 time unit after the sampling edge
  task automatic cyc(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [18:0] s, input logic [15:0] a, input logic [15:0] m);
    exp_t e;
    e.sum = s; e.avg = a; e.mx = m;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 16'h0);
    cyc(1'b0, 16'h0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: sum=0x%0h with no block expected at %0t", out_sum, $time);
      end else begin
        chk("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
        chk("out_avg", 32'(out_avg), 32'(exp_q[0].avg));
        chk("out_max", 32'(out_max), 32'(exp_q[0].mx));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum",   32'(out_sum),   0);
    chk("rst_out_avg",   32'(out_avg),   0);
    chk("rst_out_max",   32'(out_max),   0);
    chk("rst_overrun",   32'(overrun),   0);

    // back-to-back 0x0054, latency one cycle after the 8th sample
    out_ready = 1'b1;
    push(19'h002A0, 16'h0054, 16'h0054);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 16'h0054);
      chk("no_early_valid", 32'(out_valid), 0);
    end
    cyc(1'b1, 16'h0054);
    chk("latency_valid", 32'(out_valid), 1);
    cyc(1'b0, 16'h0);
    chk("accepted_t1", 32'(out_valid), 0);

    // 1..8 with gaps carrying junk data
    push(19'h00024, 16'h0004, 16'h0008);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 16'(i));
      if (i < 8) cyc(1'b0, 16'hFFFF);
    end
    chk("gap_valid", 32'(out_valid), 1);
    cyc(1'b0, 16'h0);

    // full-scale samples, no wrap
    push(19'h7FFF8, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hFFFF);
    cyc(1'b0, 16'h0);
    chk("accepted_t3", 32'(out_valid), 0);

    // overrun: second block discarded while first is held
    out_ready = 1'b0;
    push(19'h00008, 16'h0001, 16'h0001);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0001);
    chk("ovr_before", 32'(overrun), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0002);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_held_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    cyc(1'b0, 16'h0);
    chk("ovr_accepted", 32'(out_valid), 0);
    chk("ovr_sticky", 32'(overrun), 1);
    cyc(1'b0, 16'h0);
    chk("ovr_sticky2", 32'(overrun), 1);

    do_reset();
    chk("ovr_cleared", 32'(overrun), 0);

    // accept and completion on the same edge
    out_ready = 1'b0;
    push(19'h00018, 16'h0003, 16'h0003);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0003);
    push(19'h00028, 16'h0005, 16'h0005);
    for (int i = 0; i < 7; i++) cyc(1'b1, 16'h0005);
    out_ready = 1'b1;
    cyc(1'b1, 16'h0005);
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_sum",   32'(out_sum), 32'h28);
    chk("b2b_ovr",   32'(overrun), 0);
    cyc(1'b0, 16'h0);
    chk("b2b_accepted", 32'(out_valid), 0);

    // reset mid-block, with in_valid asserted during reset
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0077);
    reset = 1'b1;
    cyc(1'b1, 16'h0099);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_sum",   32'(out_sum),   0);
    chk("midrst_avg",   32'(out_avg),   0);
    chk("midrst_max",   32'(out_max),   0);
    chk("midrst_ovr",   32'(overrun),   0);
    reset = 1'b0;
    push(19'h00080, 16'h0010, 16'h0010);
    for (int i = 0; i < 7; i++) cyc(1'b1, 16'h0010);
    chk("midrst_no_early", 32'(out_valid), 0);
    cyc(1'b1, 16'h0010);
    chk("midrst_new_valid", 32'(out_valid), 1);
    cyc(1'b0, 16'h0);
    cyc(1'b0, 16'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_13_accum.md
EX_13_ACCUM -- requirements
Module: ex_13_accum

Interface
REQ-001 Parameter DW, default 16, width of input sample (matches upstream g output).
REQ-002 Parameter N_LOG2, default 3, log2 of samples per block (N = 2**N_LOG2 = 8).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data is a sample this cycle; no backpressure upstream.
REQ-006 in_data  input  DW  sample from upstream stage (g).
REQ-007 out_valid  output  1  out_sum/out_avg hold a completed block.
REQ-008 out_ready  input  1  consumer accepts output when out_valid && out_ready.
REQ-009 out_sum  output  DW+N_LOG2  sum of the N samples of the block.
REQ-010 out_avg  output  DW  out_sum >> N_LOG2, truncated.
REQ-011 out_max  output  DW  largest unsigned sample in the block.
REQ-012 overrun  output  1  sticky flag: a completed block was discarded.

Function
REQ-013 Accumulator acc (DW+N_LOG2 bits) and sample counter cnt (N_LOG2 bits) SHALL update only on cycles with in_valid=1.
REQ-014 Unsigned arithmetic; acc width SHALL guarantee no overflow for N samples of max value (8 x 0xFFFF = 0x7FFF8).
REQ-015 On in_valid with cnt==N-1, block completes: acc+in_data and max(running_max,in_data) SHALL be offered for output; acc, running_max, cnt cleared the same edge.
REQ-016 Latency: out_valid SHALL rise on the edge that samples the Nth valid sample (visible next cycle).
REQ-017 Output register FSM, two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-018 EMPTY -> FULL on block completion; FULL -> EMPTY on out_ready with no completion; FULL -> FULL on out_ready with simultaneous completion (new block loaded, no bubble).
REQ-019 In FULL, out_sum/out_avg/out_max SHALL stay stable until accepted.
REQ-020 Completion in FULL without out_ready: new block SHALL be discarded, held output unchanged, overrun set.
REQ-021 Accumulation SHALL continue regardless of output state; no input sample is ever stalled.
REQ-022 overrun SHALL be cleared only by reset.
REQ-023 out_ready while EMPTY SHALL have no effect.

Reset
REQ-024 reset=1 at a clock edge SHALL clear acc, cnt, running_max, out_sum, out_avg, out_max, out_valid, overrun to 0, state EMPTY.
REQ-025 Reset mid-block SHALL discard the partial block; the next valid sample after reset starts a new block at cnt=0.
REQ-026 reset has priority over in_valid and out_ready in the same cycle.

Structure
REQ-027 Shared package ex_13_pkg SHALL hold DW and N_LOG2 defaults and the output-state enum (EMPTY, FULL).
REQ-028 Output holding register with handshake SHALL be one sub-module, ex_13_out_reg; accumulation logic stays in ex_13_accum.

Verification
REQ-029 8 valid samples of 0x0054 back-to-back, out_ready=1 -> one cycle after 8th: out_valid=1, out_sum=0x002A0, out_avg=0x0054, out_max=0x0054; accepted next cycle.
REQ-030 Samples 1..8 with in_valid gaps (valid every other cycle) -> out_sum=0x00024, out_avg=0x0004, out_max=0x0008; gaps do not advance cnt.
REQ-031 8 samples of 0xFFFF -> out_sum=0x7FFF8, out_avg=0xFFFF, no wrap.
REQ-032 out_ready=0, 16 valid samples of 0x0001 then 0x0002 -> first block (sum 0x00008) held, second discarded, overrun=1; raise out_ready -> accepted, out_valid=0, overrun stays 1.
REQ-033 FULL with out_ready asserted on same cycle as next completion -> out_valid stays 1, new values appear next cycle, overrun=0.
REQ-034 reset asserted after 5 valid samples, then 8 samples of 0x0010 -> out_sum=0x00080, all outputs 0 during reset.
